// File: rtl/uio_bus_arbiter_if.sv
// Pad-bus sharing interface between drive/capture requesters and the uio arbiter.
// The slave modport is the arbiter side; master is the requester/pad side.
interface uio_bus_arbiter_if #(
   parameter int unsigned NREQ = 2
);
   logic                  ena;
   logic [NREQ-1:0]       drv_req;
   logic [NREQ-1:0]       drv_last;
   logic [8*NREQ-1:0]     drv_data;
   logic [NREQ-1:0]       drv_gnt;
   logic                  cap_req;
   logic [7:0]            cap_data;
   logic                  cap_valid;
   logic [7:0]            uio_in;
   logic [7:0]            uio_out;
   logic [7:0]            uio_oe;
   logic                  busy;

   modport master (
      output ena, drv_req, drv_last, drv_data, cap_req, uio_in,
      input  drv_gnt, cap_data, cap_valid, uio_out, uio_oe, busy
   );

   modport slave (
      input  ena, drv_req, drv_last, drv_data, cap_req, uio_in,
      output drv_gnt, cap_data, cap_valid, uio_out, uio_oe, busy
   );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the bidirectional uio pads: NREQ drive requesters plus one
// capture requester, with turnaround cycles inserted before the pads are released.
module uio_bus_arbiter #(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned HOLD_MAX  = 8,
   parameter int unsigned TA_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   uio_bus_arbiter_if.slave  bus
);

   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned HW = $clog2(HOLD_MAX + 1);
   localparam int unsigned TW = $clog2(TA_CYCLES + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DRIVE   = 2'd1;
   localparam logic [1:0] S_TURN    = 2'd2;
   localparam logic [1:0] S_CAPTURE = 2'd3;

   logic [1:0]      state, state_nxt;
   logic [OW-1:0]   owner, owner_nxt;
   logic [OW-1:0]   last_owner, last_owner_nxt;
   logic [HW-1:0]   hold, hold_nxt, hold_inc;
   logic [TW-1:0]   tcnt, tcnt_nxt;

   logic [NREQ-1:0] req_eff;
   logic [NREQ-1:0] others;
   logic [NREQ-1:0] gnt_c;
   logic            cap_eff;
   logic            owner_req;
   logic            owner_last;
   logic            accept_c;
   logic            release_c;
   logic [7:0]      beat;

   logic [7:0]      out_q;
   logic [7:0]      oe_q;
   logic [7:0]      cap_data_q;
   logic            cap_valid_q;

   // First requester at or after base+1 (mod NREQ); returns base when none request.
   function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [OW-1:0]   base);
      logic [OW-1:0] pick;
      logic          found;
      int unsigned   idx;
      pick  = base;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(base) + k) % NREQ;
         if (!found && req[OW'(idx)]) begin
            pick  = OW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign req_eff    = bus.drv_req & {NREQ{bus.ena}};
   assign cap_eff    = bus.cap_req & bus.ena;
   assign others     = req_eff & ~(NREQ'(1) << owner);
   assign owner_req  = bus.drv_req[owner];
   assign owner_last = bus.drv_last[owner];

   // Owner's beat mux; non-owner data never reaches the pads.
   always_comb begin
      beat = 8'h00;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (owner == OW'(i)) beat = bus.drv_data[8*i +: 8];
      end
   end

   always_comb begin
      gnt_c = '0;
      if (state == S_DRIVE && bus.ena) gnt_c[owner] = 1'b1;
   end

   assign accept_c = (state == S_DRIVE) && bus.ena && owner_req;

   // Next-state logic: arbitration in IDLE and at every DRIVE release.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      hold_nxt       = hold;
      tcnt_nxt       = tcnt;
      hold_inc       = hold + HW'(1);
      release_c      = 1'b0;

      case (state)
         S_IDLE: begin
            if (cap_eff) begin
               state_nxt = S_CAPTURE;
            end else if (|req_eff) begin
               state_nxt = S_DRIVE;
               owner_nxt = rr_pick(req_eff, last_owner);
               hold_nxt  = '0;
            end
         end

         S_DRIVE: begin
            if (accept_c) hold_nxt = hold_inc;
            release_c = (accept_c && (owner_last || hold_inc == HW'(HOLD_MAX))) ||
                        !owner_req || !bus.ena;
            if (release_c) begin
               last_owner_nxt = owner;
               hold_nxt       = '0;
               if (cap_eff || others == '0) begin
                  state_nxt = S_TURN;
                  tcnt_nxt  = '0;
               end else begin
                  owner_nxt = rr_pick(others, owner);
               end
            end
         end

         // First TURN cycle still shows the final beat through the output lag.
         S_TURN: begin
            if (tcnt == TW'(TA_CYCLES)) begin
               state_nxt = cap_eff ? S_CAPTURE : S_IDLE;
               tcnt_nxt  = '0;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
            end
         end

         S_CAPTURE: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         owner      <= '0;
         last_owner <= OW'(NREQ - 1);
         hold       <= '0;
         tcnt       <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         hold       <= hold_nxt;
         tcnt       <= tcnt_nxt;
      end
   end

   // Pad stage lags the state by one cycle so oe drops only after the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= 8'h00;
         oe_q        <= 8'h00;
         cap_data_q  <= 8'h00;
         cap_valid_q <= 1'b0;
      end else begin
         oe_q        <= (state == S_DRIVE) ? 8'hFF : 8'h00;
         cap_valid_q <= (state == S_CAPTURE);
         if (accept_c) begin
            out_q <= beat;
         end else if (state != S_DRIVE) begin
            out_q <= 8'h00;
         end
         if (state == S_CAPTURE) cap_data_q <= bus.uio_in;
      end
   end

   assign bus.drv_gnt   = gnt_c;
   assign bus.uio_out   = out_q;
   assign bus.uio_oe    = oe_q;
   assign bus.cap_data  = cap_data_q;
   assign bus.cap_valid = cap_valid_q;
   assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: expected pin beats, owners and captures are
// queued as stimulus is loaded and retired as the DUT presents them.
module tb_uio_bus_arbiter;

   localparam int unsigned NREQ      = 2;
   localparam int unsigned HOLD_MAX  = 4;
   localparam int unsigned TA_CYCLES = 1;

   logic clk = 1'b0;
   logic rst_n;

   uio_bus_arbiter_if #(.NREQ(NREQ)) bus ();

   uio_bus_arbiter #(
      .NREQ      (NREQ),
      .HOLD_MAX  (HOLD_MAX),
      .TA_CYCLES (TA_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [8:0] mq0[$];
   logic [8:0] mq1[$];
   logic [7:0] exp_q[$];
   int         exp_own_q[$];
   logic [7:0] cap_q[$];

   logic            ena_r;
   logic            cap_want;
   logic [7:0]      uio_in_r;
   int              cyc;
   int              first_acc;
   int              last_acc;
   int              cap_cyc;
   int              n_acc;
   int              gnt_cycles;
   logic [NREQ-1:0] last_gnt;
   logic [7:0]      oe_h1;
   logic [7:0]      oe_h2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic init_test();
      first_acc  = -1;
      last_acc   = -1;
      cap_cyc    = -1;
      n_acc      = 0;
      gnt_cycles = 0;
   endtask

   task automatic drive_inputs();
      bus.ena      = ena_r;
      bus.cap_req  = cap_want;
      bus.uio_in   = uio_in_r;
      bus.drv_req  = '0;
      bus.drv_last = '0;
      bus.drv_data = '0;
      if (mq0.size() != 0) begin
         bus.drv_req[0]      = 1'b1;
         bus.drv_last[0]     = mq0[0][8];
         bus.drv_data[7:0]   = mq0[0][7:0];
      end
      if (mq1.size() != 0) begin
         bus.drv_req[1]      = 1'b1;
         bus.drv_last[1]     = mq1[0][8];
         bus.drv_data[15:8]  = mq1[0][7:0];
      end
   endtask

   // One clock cycle: drive, observe grants, cross the edge, retire pin/capture output.
   task automatic tick();
      logic [NREQ-1:0] acc;
      int              who;
      logic [7:0]      e;
      drive_inputs();
      #1;
      last_gnt = bus.drv_gnt;
      acc      = bus.drv_gnt & bus.drv_req;
      if (bus.drv_gnt != '0) begin
         gnt_cycles++;
         chk("gnt_onehot", 32'($countones(bus.drv_gnt)), 32'd1);
      end
      if (acc != '0) begin
         who = acc[1] ? 1 : 0;
         if (exp_own_q.size() == 0) chk("owner_extra", 32'(who), 32'hFFFF_FFFF);
         else chk("owner", 32'(who), 32'(exp_own_q.pop_front()));
         if (who == 0) void'(mq0.pop_front());
         else void'(mq1.pop_front());
         n_acc++;
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("oe_legal", 32'(bus.uio_oe == 8'hFF || bus.uio_oe == 8'h00), 32'd1);
      if (acc != '0) begin
         if (exp_q.size() == 0) begin
            chk("beat_extra", 32'(bus.uio_out), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("pin_data", 32'(bus.uio_out), 32'(e));
         end
         chk("pin_oe", 32'(bus.uio_oe), 32'hFF);
      end
      if (bus.cap_valid) begin
         cap_cyc  = cyc;
         cap_want = 1'b0;
         chk("cap_oe_before", 32'(oe_h2), 32'h00);
         chk("cap_oe_during", 32'(oe_h1), 32'h00);
         if (cap_q.size() == 0) chk("cap_extra", 32'(bus.cap_data), 32'hFFFF_FFFF);
         else chk("cap_data", 32'(bus.cap_data), 32'(cap_q.pop_front()));
      end
      oe_h2 = oe_h1;
      oe_h1 = bus.uio_oe;
   endtask

   task automatic drain_idle(input int bound);
      for (int k = 0; k < bound && bus.busy; k++) tick();
      chk("drain_idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic push_beat(input int who, input logic [7:0] d, input logic last);
      if (who == 0) mq0.push_back({last, d});
      else mq1.push_back({last, d});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      ena_r    = 1'b1;
      cap_want = 1'b0;
      uio_in_r = 8'h00;
      cyc      = 0;
      oe_h1    = 8'h00;
      oe_h2    = 8'h00;
      last_gnt = '0;
      init_test();
      drive_inputs();

      // Reset values
      #12;
      chk("rst_oe",        32'(bus.uio_oe),    32'h00);
      chk("rst_out",       32'(bus.uio_out),   32'h00);
      chk("rst_gnt",       32'(bus.drv_gnt),   32'h0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_cap_valid", 32'(bus.cap_valid), 32'd0);
      chk("rst_cap_data",  32'(bus.cap_data),  32'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention: 4 beats of 0, 4 of 1, 4 of 0, hand-over without turnaround
      init_test();
      for (int k = 0; k < 8; k++) push_beat(0, 8'(8'hA0 + k), (k == 7));
      for (int k = 0; k < 4; k++) push_beat(1, 8'(8'hB0 + k), (k == 3));
      for (int k = 0; k < 4; k++) begin exp_q.push_back(8'(8'hA0 + k)); exp_own_q.push_back(0); end
      for (int k = 0; k < 4; k++) begin exp_q.push_back(8'(8'hB0 + k)); exp_own_q.push_back(1); end
      for (int k = 4; k < 8; k++) begin exp_q.push_back(8'(8'hA0 + k)); exp_own_q.push_back(0); end
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
      chk("t3_drained",     32'(exp_q.size()),        32'd0);
      chk("t3_gnt_cycles",  32'(gnt_cycles),          32'd12);
      chk("t3_span",        32'(last_acc - first_acc), 32'd11);
      drain_idle(10);

      // Single burst 11,22,33 then turnaround and idle
      init_test();
      push_beat(0, 8'h11, 1'b0);
      push_beat(0, 8'h22, 1'b0);
      push_beat(0, 8'h33, 1'b1);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      repeat (3) exp_own_q.push_back(0);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      chk("t2_drained",    32'(exp_q.size()), 32'd0);
      chk("t2_gnt_cycles", 32'(gnt_cycles),   32'd3);
      tick();
      chk("t2_ta_oe",   32'(bus.uio_oe), 32'h00);
      chk("t2_ta_busy", 32'(bus.busy),   32'd1);
      tick();
      chk("t2_idle_busy", 32'(bus.busy),   32'd0);
      chk("t2_idle_oe",   32'(bus.uio_oe), 32'h00);

      // Capture requested mid-burst: burst finishes, then turnaround, then capture
      init_test();
      uio_in_r = 8'h5A;
      push_beat(0, 8'h41, 1'b0);
      push_beat(0, 8'h42, 1'b0);
      push_beat(0, 8'h43, 1'b1);
      exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
      repeat (3) exp_own_q.push_back(0);
      tick();
      tick();
      cap_want = 1'b1;
      cap_q.push_back(8'h5A);
      for (int k = 0; k < 20 && (cap_q.size() != 0 || bus.busy); k++) tick();
      chk("t4_cap_done", 32'(cap_q.size()), 32'd0);
      chk("t4_beats",    32'(n_acc),        32'd3);
      tick();
      chk("t4_cap_pulse", 32'(bus.cap_valid), 32'd0);
      chk("t4_cap_hold",  32'(bus.cap_data),  32'h5A);

      // Capture and requester 1 together in IDLE: capture first
      init_test();
      uio_in_r = 8'hC3;
      cap_want = 1'b1;
      cap_q.push_back(8'hC3);
      push_beat(1, 8'hC1, 1'b0);
      push_beat(1, 8'hC2, 1'b1);
      exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
      repeat (2) exp_own_q.push_back(1);
      for (int k = 0; k < 20 && (exp_q.size() != 0 || cap_q.size() != 0); k++) tick();
      chk("t5_drained",   32'(exp_q.size() + cap_q.size()), 32'd0);
      chk("t5_cap_first", 32'(cap_cyc >= 0 && cap_cyc < first_acc), 32'd1);
      drain_idle(10);

      // Enable drop mid-burst: grant removed, turnaround, remaining beats later
      init_test();
      push_beat(0, 8'h61, 1'b0);
      push_beat(0, 8'h62, 1'b0);
      push_beat(0, 8'h63, 1'b1);
      exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
      repeat (3) exp_own_q.push_back(0);
      tick();
      tick();
      ena_r = 1'b0;
      tick();
      chk("t6_gnt_off", 32'(last_gnt), 32'h0);
      chk("t6_busy",    32'(bus.busy), 32'd1);
      ena_r = 1'b1;
      tick();
      chk("t6_turn_oe", 32'(bus.uio_oe), 32'h00);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      chk("t6_drained", 32'(exp_q.size()), 32'd0);
      chk("t6_beats",   32'(n_acc),        32'd3);
      drain_idle(10);

      // Asynchronous reset in the middle of a burst
      init_test();
      for (int k = 0; k < 4; k++) push_beat(0, 8'(8'h71 + k), (k == 3));
      exp_q.push_back(8'h71); exp_q.push_back(8'h72);
      repeat (2) exp_own_q.push_back(0);
      tick();
      tick();
      tick();
      chk("t1_pre_oe", 32'(bus.uio_oe), 32'hFF);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t1_rst_oe",   32'(bus.uio_oe),  32'h00);
      chk("t1_rst_out",  32'(bus.uio_out), 32'h00);
      chk("t1_rst_gnt",  32'(bus.drv_gnt), 32'h0);
      chk("t1_rst_busy", 32'(bus.busy),    32'd0);
      mq0.delete();
      mq1.delete();
      exp_q.delete();
      exp_own_q.delete();
      cap_q.delete();
      oe_h1 = 8'h00;
      oe_h2 = 8'h00;
      drive_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // After reset, round-robin starts at requester 0
      init_test();
      push_beat(0, 8'h81, 1'b1);
      push_beat(1, 8'h91, 1'b1);
      exp_q.push_back(8'h81); exp_q.push_back(8'h91);
      exp_own_q.push_back(0); exp_own_q.push_back(1);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      chk("t7_drained", 32'(exp_q.size()), 32'd0);
      drain_idle(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
